uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised successor to the fixed 8N1 serial receiver. It deserialises an async UART line into words of
//  DATA_BITS bits, with optional even/odd parity and 1 or 2 stop bits. Each bit is a 3-sample majority vote.
//  False starts are rejected. Each frame goes to a one-entry output register with a valid/ready handshake and
//  per-frame error flags. It sits between the pad-side DataIn line and the command decoder.
// PARAMETERS
//  CLKS_PER_BIT  4800  Clock cycles per bit; legal range >= 8.
//  DATA_BITS     8     Data bits per frame, 5..9, sent LSB first.
//  PARITY_MODE   0     0 = none, 1 = even, 2 = odd.
//  STOP_BITS     1     Stop bits, 1 or 2.
// PORTS
//  Clock      in   1          System clock; all state changes on its rising edge.
//  Reset      in   1          Asynchronous, active-low reset (0 = reset asserted).
//  DataIn     in   1          Asynchronous serial line; idle level is 1.
//  DataReady  in   1          Consumer accepts DataOut this cycle.
//  DataOut    out  DATA_BITS  Received word, LSB = first data bit on the wire.
//  DataValid  out  1          DataOut and the flags hold an unconsumed frame.
//  ParityErr  out  1          Held frame failed the parity check (always 0 when PARITY_MODE = 0).
//  FrameErr   out  1          Held frame had a stop bit sampled as 0.
//  Overrun    out  1          Sticky: at least one frame was dropped because the register was full.
//  Busy       out  1          Frame reception is in progress (state is not IDLE).
// BEHAVIOUR
//  - Reset asserted, at any time including mid-frame:
//      * DataOut = 0; DataValid, ParityErr, FrameErr, Overrun, Busy = 0.
//      * Synchroniser flops = 1; FSM = IDLE; bit counter = 0.
//  - Synchroniser: 2-flop on DataIn, then a 3-deep history of the synced bit (s0, s1, s2).
//      * Majority vote maj = (s0&s1)|(s1&s2)|(s0&s2).
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//  - IDLE: synced bit = 0 -> START, clear counter.
//  - START: count to CLKS_PER_BIT/2 - 1, then test maj.
//      * maj = 1: false start -> IDLE, no flags, nothing delivered.
//      * maj = 0: -> DATA, clear counter.
//  - DATA: count to CLKS_PER_BIT - 1 (mid-bit), then shift maj in LSB first and clear the counter.
//      * After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else -> STOP.
//  - PARITY: sample at mid-bit, same counting as DATA.
//      * Error if XOR(data, sampled bit) != (PARITY_MODE == 2).
//  - STOP: sample STOP_BITS times at mid-bit.
//      * Any 0 sets the frame's FrameErr.
//      * On the last stop sample the frame is complete; no wait for end-of-bit, so back-to-back frames are allowed.
//      * Complete with no FrameErr -> IDLE.
//      * Complete with FrameErr -> BREAK.
//  - BREAK: hold until the synced bit = 1, then -> IDLE. A held-low line gives exactly one errored frame.
//  - Delivery latency: DataValid rises on the cycle after the final stop-bit sample.
//      * Counted from the DataIn falling edge: 2 + CLKS_PER_BIT/2 + (DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT + 1 clocks,
//        where P = (PARITY_MODE != 0).
//  - Handshake: a transfer happens in a cycle with DataValid & DataReady.
//      * DataValid deasserts the next cycle unless a new frame completes in the same cycle.
//      * DataOut and the flags are stable while DataValid = 1.
//  - Frame complete while DataValid = 1 and DataReady = 0: the new frame is dropped, held data is unchanged,
//    and Overrun is set.
//  - Frame complete in the same cycle as a transfer: the new frame loads, DataValid stays 1, no overrun.
//  - Overrun clears only on a transfer and only if no drop happens in that cycle; otherwise it stays set.
//  - Errored frames are still delivered, with their flags; ParityErr and FrameErr are loaded per frame.
// TESTING
//  1. Default params; DataIn = 0,1,0,1,0,1,0,1,0,1 with 4800 clocks per level; DataReady = 1
//     -> DataOut = 0x55, DataValid high for 1 cycle, all flags 0.
//  2. CLKS_PER_BIT = 16, PARITY_MODE = 1; send 0xA5 with parity bit 0, then with parity bit 1
//     -> first frame ParityErr = 0, second frame ParityErr = 1.
//  3. CLKS_PER_BIT = 16; 4-clock low glitch on an idle line
//     -> back to IDLE, DataValid stays 0, Busy pulses.
//  4. CLKS_PER_BIT = 16; DataReady = 0; send 0x11 then 0x22 back-to-back
//     -> DataOut = 0x11 held, Overrun = 1; raise DataReady -> one transfer of 0x11, Overrun clears.
//  5. CLKS_PER_BIT = 16; hold DataIn = 0 for 40 bit times, then 1
//     -> one frame DataOut = 0x00 with FrameErr = 1, no further frames, then a new 0x3C frame received clean.
//  6. Pull Reset low mid-DATA of a 0xF0 frame; release; send 0x0F
//     -> all outputs 0 during reset, only 0x0F delivered.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// The line is passed through a 2-flop synchroniser and a 3-deep history, and each bit is a
// 3-sample majority vote. The receiver checks an optional parity bit and 1 or 2 stop bits,
// and rejects false starts. Each received word goes into a one-entry output register with a
// valid/ready handshake and per-frame error flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 4800,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 DataIn,
    input  logic                 DataReady,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataValid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY_MODE != 0);
    localparam logic             ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    // A parity error is when the XOR of the data and the parity bit differs from the expected value.
    // That value is 1 for odd parity and 0 for even parity.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic pbit, input logic odd);
        return ((^data) ^ pbit) != odd;
    endfunction

    logic                 sync1_q, sync2_q;
    logic [2:0]           hist_q;
    logic                 maj_s;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_s, done_ferr_s, xfer_s;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 operr_q, operr_d;
    logic                 oferr_q, oferr_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q;

    assign maj_s  = maj3(hist_q[0], hist_q[1], hist_q[2]);
    assign xfer_s = valid_q & DataReady;

    // Synchronise the async line and keep a 3-sample history of it for the vote.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= DataIn;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
        end
    end

    // Frame FSM next state: bit timing, data shift, parity and stop checks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        done_s      = 1'b0;
        done_ferr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = maj_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {maj_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = parity_mismatch(shift_q, maj_s, ODD_PARITY);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~maj_s;
                    if (bit_q == STOP_LAST) begin
                        // The frame completes at the last stop sample, so the next start edge can follow right away.
                        done_s      = 1'b1;
                        done_ferr_s = ferr_q | ~maj_s;
                        bit_d       = 4'd0;
                        state_d     = done_ferr_s ? ST_BREAK : ST_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // Wait for the line to return high, so a held-low line gives only one errored frame.
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next state: load, drop with overrun, or consume on a transfer.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        operr_d   = operr_q;
        oferr_d   = oferr_q;
        overrun_d = overrun_q;
        if (done_s) begin
            if (!valid_q || DataReady) begin
                dout_d  = shift_q;
                valid_d = 1'b1;
                operr_d = HAS_PARITY & perr_q;
                oferr_d = done_ferr_s;
                if (xfer_s) begin
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = overrun_q;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer_s) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // FSM state, bit timing and frame accumulation registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Registered outputs for the consumer.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            operr_q   <= 1'b0;
            oferr_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            operr_q   <= operr_d;
            oferr_q   <= oferr_d;
            overrun_q <= overrun_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign DataOut   = dout_q;
    assign DataValid = valid_q;
    assign ParityErr = operr_q;
    assign FrameErr  = oferr_q;
    assign Overrun   = overrun_q;
    assign Busy      = busy_q;

endmodule
